// File: rtl/nvdla_rws32x16_fifo_ctrl_pkg.sv
// Shared constants and pointer/counter types for the 32x16 RWS FIFO controller.
package nvdla_rws32x16_fifo_ctrl_pkg;

  localparam int RWS32X16_DEPTH = 32;
  localparam int RWS32X16_AW    = 5;
  localparam int RWS32X16_DW    = 16;

  typedef logic [RWS32X16_AW-1:0] ptr_t;
  typedef logic [RWS32X16_AW:0]   cnt_t;

endpackage

// File: rtl/nvdla_rws32x16_fifo_ctrl_ram.sv
// Behavioural nv_ram_rws_32x16: synchronous write, registered read address, dout
// taken combinationally from the array at the latched address.
module nv_ram_rws_32x16
  import nvdla_rws32x16_fifo_ctrl_pkg::*;
(
  input  logic                   clk,
  input  ptr_t                   ra,
  input  logic                   re,
  output logic [RWS32X16_DW-1:0] dout,
  input  ptr_t                   wa,
  input  logic                   we,
  input  logic [RWS32X16_DW-1:0] di,
  input  logic [31:0]            pwrbus_ram_pd
);

  logic [RWS32X16_DW-1:0] mem [RWS32X16_DEPTH];
  ptr_t                   ra_d;
  logic                   unused_pwrbus;

  // Power-bus controls have no effect on the behavioural array.
  assign unused_pwrbus = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_d <= ra;
  end

  assign dout = mem[ra_d];

endmodule

// File: rtl/nvdla_rws32x16_fifo_ctrl.sv
// Valid/ready FIFO controller around one nv_ram_rws_32x16 (32 x 16).
// Optional status outputs enabled by NVDLA_RWS32X16_FIFO_STATUS_EN.
module nvdla_rws32x16_fifo_ctrl
  import nvdla_rws32x16_fifo_ctrl_pkg::*;
(
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   wr_pvld,
  output logic                   wr_prdy,
  input  logic [RWS32X16_DW-1:0] wr_pd,
  output logic                   rd_pvld,
  input  logic                   rd_prdy,
  output logic [RWS32X16_DW-1:0] rd_pd,
`ifdef NVDLA_RWS32X16_FIFO_STATUS_EN
  output cnt_t                   fifo_count,
  output logic                   fifo_ovf,
  output logic                   fifo_udf,
`endif
  input  logic [31:0]            pwrbus_ram_pd
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;
  cnt_t unread;
  logic push;
  logic pop;
  logic prefetch;

  assign wr_prdy  = (count != cnt_t'(RWS32X16_DEPTH));
  assign push     = wr_pvld & wr_prdy;
  assign pop      = rd_pvld & rd_prdy;
  // count includes the presented head, so its slot stays reserved until popped.
  assign prefetch = (unread != '0) & (~rd_pvld | rd_prdy);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      unread  <= '0;
      rd_pvld <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + ptr_t'(1);
      if (prefetch) rd_ptr <= rd_ptr + ptr_t'(1);
      count  <= count + cnt_t'(push) - cnt_t'(pop);
      unread <= unread + cnt_t'(push) - cnt_t'(prefetch);
      if (prefetch)     rd_pvld <= 1'b1;
      else if (rd_prdy) rd_pvld <= 1'b0;
    end
  end

`ifdef NVDLA_RWS32X16_FIFO_STATUS_EN
  assign fifo_count = count;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      fifo_ovf <= 1'b0;
      fifo_udf <= 1'b0;
    end else begin
      if (wr_pvld & ~wr_prdy) fifo_ovf <= 1'b1;
      if (rd_prdy & ~rd_pvld) fifo_udf <= 1'b1;
    end
  end
`endif

  nv_ram_rws_32x16 u_ram (
    .clk           (nvdla_core_clk),
    .ra            (rd_ptr),
    .re            (prefetch),
    .dout          (rd_pd),
    .wa            (wr_ptr),
    .we            (push),
    .di            (wr_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

endmodule

// File: doc/nvdla_rws32x16_fifo_ctrl.md
Name: nvdla_rws32x16_fifo_ctrl

Overview:
- Valid/ready FIFO controller that sequences one nv_ram_rws_32x16 instance: 32 entries of 16 bits.
- Owns the write/read pointers, occupancy counting and read prefetch, and drives the RAM's registered-read-address port so that rd_pd comes directly from RAM dout.
- Sits between a producer and a consumer inside a core sub-unit, as a small elastic buffer.

Parameters:
- DEPTH, 32, entry count; fixed by the RAM macro and not overridable.
- WIDTH, 16, payload width; fixed by the RAM macro.
- AW, 5, pointer width, log2(DEPTH).

Ports:
- nvdla_core_clk  in  1  single clock for the block and the RAM.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- wr_pvld  in  1  producer data valid.
- wr_prdy  out  1  FIFO can accept a write.
- wr_pd  in  16  write payload.
- rd_pvld  out  1  head entry presented.
- rd_prdy  in  1  consumer accepts the head entry.
- rd_pd  out  16  head payload; this is RAM dout.
- pwrbus_ram_pd  in  32  passed unchanged to the RAM.

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, count=0, unread=0, rd_pvld=0. wr_prdy=1 out of reset, combinational from count. rd_pd is undefined until the first prefetch.
- Write: on wr_pvld&wr_prdy, RAM we=1, wa=wr_ptr, di=wr_pd. wr_ptr wraps 31->0. count+1 and unread+1 take effect next cycle.
- wr_prdy = (count != 32). There is no same-cycle pop bypass: a full FIFO with a pop this cycle still shows wr_prdy=0 until the next cycle.
- Prefetch condition: unread != 0 && (!rd_pvld || rd_prdy).
- Prefetch action: RAM re=1, ra=rd_ptr, rd_ptr+1 (wraps), unread-1, and rd_pvld<=1 next cycle. Otherwise, if rd_prdy, rd_pvld<=0.
- Read data hold: RAM ra_d holds the presented address, so rd_pd is stable while rd_pvld && !rd_prdy.
- Pop: on rd_pvld&rd_prdy, count-1. The presented slot is freed only on pop, never on prefetch, so a write cannot overwrite the head entry.
- Simultaneous push and pop: count unchanged. A push and a prefetch in the same cycle give unread unchanged.
- Latency: a write in cycle t is readable in the array at t+1, prefetched at t+1, and rd_pvld=1 at t+2. Minimum fall-through is 2 cycles.
- Throughput: 1 entry per cycle sustained in both directions.
- Counter widths: count and unread are 6 bits and never exceed 32.
- Illegal operations: pushing when full or popping when rd_pvld=0 are ignored; no state changes.
- Reset mid-operation clears all pointers and counters immediately. RAM contents are not cleared; data is lost.
- State view, encoded by (unread, rd_pvld):
  - EMPTY (0,0) goes to PRIMING on a push.
  - PRIMING (>0,0) goes to PRESENT.
  - PRESENT (x,1) stays on a stall or on pop with refill; goes to EMPTY on pop with unread=0.

Optional Feature:
- Macro: NVDLA_RWS32X16_FIFO_STATUS_EN.
- When defined, add outputs:
  - fifo_count [5:0]: registered count.
  - fifo_ovf: sticky, set on wr_pvld&!wr_prdy.
  - fifo_udf: sticky, set on rd_prdy&!rd_pvld.
  - Both sticky bits are cleared only by reset.
- When undefined, these ports and flops are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Constants: RWS32X16_DEPTH=32, RWS32X16_AW=5, RWS32X16_DW=16.
  - Typedefs: ptr_t [4:0], cnt_t [5:0].
- One sub-module: the nv_ram_rws_32x16 instance. Pointer and count logic stays in this module.

Test Plan:
- Reset, then 1 push of 0xA5A5 with rd_prdy=1 -> rd_pvld rises 2 cycles later with rd_pd=0xA5A5, then drops after the pop; count returns to 0.
- 32 pushes (0x0000..0x001F) with rd_prdy=0 -> wr_prdy=0 after the 32nd; a 33rd push is ignored; drain yields 0x0000..0x001F in order.
- Continuous push and pop at 1/cycle for 100 entries -> output order preserved, no gap after the initial 2-cycle fill, wr_prdy stays 1.
- Full FIFO, hold rd_prdy=0 for 5 cycles while wr_pvld=1 -> rd_pd stable at the head value, wr_prdy=0 throughout, no overwrite of the head.
- Pointer wrap: push/pop 40 entries with random rd_prdy stalls -> data matches the scoreboard across the 31->0 wrap.
- Reset asserted with 10 entries queued -> rd_pvld=0 and wr_prdy=1 immediately. With NVDLA_RWS32X16_FIFO_STATUS_EN: fifo_count=0, and fifo_ovf clears after having been set by an overflow push.
